// File: rtl/vga_timing_pkg.sv
// Shared constants for the raster timing generator: standard video modes and sync polarities.
package vga_timing_pkg;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } vga_mode_t;

  // 640x480@60 wants a 25 MHz pixel rate, i.e. divide-by-2 from 50 MHz
  localparam vga_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: SYNC_ACTIVE_LOW, vs_pol: SYNC_ACTIVE_LOW
  };

  localparam vga_mode_t MODE_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: SYNC_ACTIVE_HIGH, vs_pol: SYNC_ACTIVE_HIGH
  };

  function automatic int mode_h_total(input vga_mode_t m);
    return m.h_active + m.h_fp + m.h_sync + m.h_bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel enable, syncs, data enable, coordinates, address and strobes.
interface vga_timing_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10,
  parameter int A_W = 19
);
  logic           pix_ce;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [A_W-1:0] addr;
  logic           line_start;
  logic           frame_start;

  modport master (output pix_ce, hsync, vsync, de, x, y, addr, line_start, frame_start);
  modport slave  (input  pix_ce, hsync, vsync, de, x, y, addr, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Integer divider producing a registered one-cycle clock-enable every DIV cycles of clk50.
module clk_en_div #(
  parameter int DIV = 2
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic en,
  output logic ce
);
  localparam int C_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [C_W-1:0] div_cnt_reg;
  logic           div_last;

  assign div_last = (32'(div_cnt_reg) == DIV - 1);

  // Registered so that ce is low in the reset state even when DIV=1
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      ce          <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      ce          <= 1'b0;
    end else if (div_last) begin
      div_cnt_reg <= '0;
      ce          <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
      ce          <= 1'b0;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters plus pixel-aligned registered outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = MODE_640X480_60.h_active,
  parameter int   H_FP     = MODE_640X480_60.h_fp,
  parameter int   H_SYNC   = MODE_640X480_60.h_sync,
  parameter int   H_BP     = MODE_640X480_60.h_bp,
  parameter int   V_ACTIVE = MODE_640X480_60.v_active,
  parameter int   V_FP     = MODE_640X480_60.v_fp,
  parameter int   V_SYNC   = MODE_640X480_60.v_sync,
  parameter int   V_BP     = MODE_640X480_60.v_bp,
  parameter logic HS_POL   = MODE_640X480_60.hs_pol,
  parameter logic VS_POL   = MODE_640X480_60.vs_pol
) (
  input  logic         clk50,
  input  logic         rst_n,
  input  logic         en,
  vga_timing_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int A_W     = $clog2(H_ACTIVE * V_ACTIVE);

  logic           pix_ce;
  logic [X_W-1:0] h_cnt_reg;
  logic [Y_W-1:0] v_cnt_reg;
  logic [A_W-1:0] addr_cnt_reg;
  logic           h_last, v_last, de_now, hs_now, vs_now;

  clk_en_div #(.DIV(CLK_DIV)) u_clk_en_div (
    .clk50 (clk50),
    .rst_n (rst_n),
    .en    (en),
    .ce    (pix_ce)
  );

  assign vif.pix_ce = pix_ce;

  assign h_last = (h_cnt_reg == X_W'(H_TOTAL - 1));
  assign v_last = (v_cnt_reg == Y_W'(V_TOTAL - 1));
  assign de_now = (32'(h_cnt_reg) < H_ACTIVE) && (32'(v_cnt_reg) < V_ACTIVE);
  assign hs_now = (32'(h_cnt_reg) >= H_ACTIVE + H_FP) &&
                  (32'(h_cnt_reg) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs_now = (32'(v_cnt_reg) >= V_ACTIVE + V_FP) &&
                  (32'(v_cnt_reg) <  V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      addr_cnt_reg    <= '0;
      vif.x           <= '0;
      vif.y           <= '0;
      vif.addr        <= '0;
      vif.de          <= 1'b0;
      vif.hsync       <= ~HS_POL;
      vif.vsync       <= ~VS_POL;
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
    end else if (!en) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      addr_cnt_reg    <= '0;
      vif.x           <= '0;
      vif.y           <= '0;
      vif.addr        <= '0;
      vif.de          <= 1'b0;
      vif.hsync       <= ~HS_POL;
      vif.vsync       <= ~VS_POL;
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
    end else begin
      // Strobes last one clk50 cycle; everything else holds until the next pixel
      vif.line_start  <= 1'b0;
      vif.frame_start <= 1'b0;
      if (pix_ce) begin
        h_cnt_reg <= h_last ? '0 : h_cnt_reg + 1'b1;
        if (h_last)
          v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
        // Running address replaces y*H_ACTIVE+x; it only moves on visible pixels
        if (h_last && v_last)
          addr_cnt_reg <= '0;
        else if (de_now)
          addr_cnt_reg <= addr_cnt_reg + 1'b1;
        vif.x           <= h_cnt_reg;
        vif.y           <= v_cnt_reg;
        vif.addr        <= addr_cnt_reg;
        vif.de          <= de_now;
        vif.hsync       <= hs_now ? HS_POL : ~HS_POL;
        vif.vsync       <= vs_now ? VS_POL : ~VS_POL;
        vif.line_start  <= (h_cnt_reg == '0);
        vif.frame_start <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench: three generator instances checked every clk50 cycle against an arithmetic model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int div, ha, hf, hs, hb, va, vf, vs, vb, hp, vp;
  } cfg_t;

  typedef struct {
    int pix_ce, hsync, vsync, de, x, y, addr, ls, fs;
  } pix_t;

  localparam int DX = $clog2(800), DY = $clog2(525), DA = $clog2(640 * 480);
  localparam int MX = $clog2(24),  MY = $clog2(17),  MA = $clog2(16 * 10);
  localparam int SX = $clog2(12),  SY = $clog2(7),   SA = $clog2(8 * 4);

  logic clk50 = 1'b0;
  logic rst_n_d = 1'b0, en_d = 1'b1;
  logic rst_n_m = 1'b0, en_m = 1'b1;
  logic rst_n_s = 1'b0, en_s = 1'b1;

  int errors = 0;
  int checks = 0;

  cfg_t cfg_d, cfg_m, cfg_s;

  always #5 clk50 = ~clk50;

  vga_timing_if #(.X_W(DX), .Y_W(DY), .A_W(DA)) if_d ();
  vga_timing_if #(.X_W(MX), .Y_W(MY), .A_W(MA)) if_m ();
  vga_timing_if #(.X_W(SX), .Y_W(SY), .A_W(SA)) if_s ();

  vga_timing_gen u_dflt (.clk50(clk50), .rst_n(rst_n_d), .en(en_d), .vif(if_d));

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_mid (.clk50(clk50), .rst_n(rst_n_m), .en(en_m), .vif(if_m));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (.clk50(clk50), .rst_n(rst_n_s), .en(en_s), .vif(if_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // n = clk50 edges since the generator last left reset (0 = in reset).
  // Pixel p is shown after the (p+1)-th enable pulse has been consumed.
  function automatic pix_t model(input cfg_t c, input int n);
    pix_t e;
    int ht, vt, k, p, h, v;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e = '{pix_ce: 0, hsync: (c.hp == 0), vsync: (c.vp == 0), de: 0,
          x: 0, y: 0, addr: 0, ls: 0, fs: 0};
    if (n <= 0) return e;
    e.pix_ce = (n % c.div == 0);
    k = (n - 1) / c.div;
    if (k == 0) return e;
    p = k - 1;
    h = p % ht;
    v = (p / ht) % vt;
    e.x     = h;
    e.y     = v;
    e.de    = (h < c.ha) && (v < c.va);
    e.addr  = v * c.ha + h;
    e.hsync = ((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs)) ? c.hp : (c.hp == 0);
    e.vsync = ((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs)) ? c.vp : (c.vp == 0);
    e.ls    = ((n - 1) % c.div == 0) && (h == 0);
    e.fs    = e.ls && (v == 0);
    return e;
  endfunction

  task automatic check_pix(input string inst, input pix_t o, input pix_t e);
    check({inst, ".pix_ce"},      o.pix_ce, e.pix_ce);
    check({inst, ".hsync"},       o.hsync,  e.hsync);
    check({inst, ".vsync"},       o.vsync,  e.vsync);
    check({inst, ".de"},          o.de,     e.de);
    check({inst, ".x"},           o.x,      e.x);
    check({inst, ".y"},           o.y,      e.y);
    check({inst, ".line_start"},  o.ls,     e.ls);
    check({inst, ".frame_start"}, o.fs,     e.fs);
    if (e.de != 0 || e.x == 0 && e.y == 0)
      check({inst, ".addr"}, o.addr, e.addr);
  endtask

  function automatic pix_t sample_d();
    return '{pix_ce: int'(if_d.pix_ce), hsync: int'(if_d.hsync), vsync: int'(if_d.vsync),
             de: int'(if_d.de), x: int'(if_d.x), y: int'(if_d.y), addr: int'(if_d.addr),
             ls: int'(if_d.line_start), fs: int'(if_d.frame_start)};
  endfunction

  function automatic pix_t sample_m();
    return '{pix_ce: int'(if_m.pix_ce), hsync: int'(if_m.hsync), vsync: int'(if_m.vsync),
             de: int'(if_m.de), x: int'(if_m.x), y: int'(if_m.y), addr: int'(if_m.addr),
             ls: int'(if_m.line_start), fs: int'(if_m.frame_start)};
  endfunction

  function automatic pix_t sample_s();
    return '{pix_ce: int'(if_s.pix_ce), hsync: int'(if_s.hsync), vsync: int'(if_s.vsync),
             de: int'(if_s.de), x: int'(if_s.x), y: int'(if_s.y), addr: int'(if_s.addr),
             ls: int'(if_s.line_start), fs: int'(if_s.frame_start)};
  endfunction

  initial begin : mon_d
    int n = 0;
    forever begin
      @(posedge clk50);
      if (!rst_n_d || !en_d) n = 0; else n++;
      #1 check_pix("dflt", sample_d(), model(cfg_d, n));
    end
  end

  initial begin : mon_m
    int n = 0;
    forever begin
      @(posedge clk50);
      if (!rst_n_m || !en_m) n = 0; else n++;
      #1 check_pix("mid", sample_m(), model(cfg_m, n));
    end
  end

  initial begin : mon_s
    int n = 0;
    forever begin
      @(posedge clk50);
      if (!rst_n_s || !en_s) n = 0; else n++;
      #1 check_pix("small", sample_s(), model(cfg_s, n));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic run_dflt();
    cycles(3);
    rst_n_d = 1'b1;
    cycles(3300);
    en_d = 1'b0;
    cycles(10);
    en_d = 1'b1;
    cycles(1700 + $urandom_range(0, 40));
    #2 rst_n_d = 1'b0;
    #1 check_pix("dflt_arst", sample_d(), model(cfg_d, 0));
    cycles(2);
    rst_n_d = 1'b1;
    cycles(700);
  endtask

  task automatic run_mid();
    cycles(2);
    rst_n_m = 1'b1;
    cycles(1800);
    for (int i = 0; i < 8; i++) begin
      cycles($urandom_range(100, 900));
      if ($urandom_range(0, 1) == 0) begin
        en_m = 1'b0;
        cycles($urandom_range(1, 12));
        en_m = 1'b1;
      end else begin
        #($urandom_range(1, 3)) rst_n_m = 1'b0;
        #1 check_pix("mid_arst", sample_m(), model(cfg_m, 0));
        cycles($urandom_range(1, 4));
        rst_n_m = 1'b1;
      end
    end
  endtask

  task automatic run_small();
    cycles(4);
    rst_n_s = 1'b1;
    cycles(300);
    for (int i = 0; i < 8; i++) begin
      cycles($urandom_range(20, 200));
      en_s = 1'b0;
      cycles($urandom_range(1, 10));
      en_s = 1'b1;
    end
    cycles(200);
  endtask

  initial begin
    cfg_d = '{div: 2, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, hp: 0, vp: 0};
    cfg_m = '{div: 2, ha: 16,  hf: 2,  hs: 3,  hb: 3,  va: 10,  vf: 2,  vs: 2, vb: 3,  hp: 0, vp: 0};
    cfg_s = '{div: 1, ha: 8,   hf: 1,  hs: 2,  hb: 1,  va: 4,   vf: 1,  vs: 1, vb: 1,  hp: 1, vp: 1};
    fork
      run_dflt();
      run_mid();
      run_small();
    join
    @(negedge clk50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
